// File: rtl/serial_mag_cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// result codes that downstream control logic can reuse.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

  // Packs the three one-hot result flags into a CMP_* code.
  function automatic logic [1:0] cmp_encode(input logic eq, input logic gt, input logic lt);
    logic [1:0] code;
    code = CMP_EQ;
    if (gt) code = CMP_GT;
    else if (lt) code = CMP_LT;
    else if (eq) code = CMP_EQ;
    return code;
  endfunction

endpackage

// File: rtl/serial_mag_cmp_bit_cell.sv
// One-bit equal/greater/lower cell, purely combinational.
module cmp_bit_cell (
  input  logic x,
  input  logic y,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(x ^ y);
  assign gt = x & ~y;
  assign lt = ~x & y;

endmodule

// File: rtl/serial_mag_cmp.sv
// Serial MSB-first magnitude comparator: one bit pair per clock, exits at the
// first differing bit and holds a registered result until it is consumed.
module serial_mag_cmp
  import cmp_pkg::*;
#(
  parameter  int W     = 8,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             greater,
  output logic             lower,
  output logic [IDX_W-1:0] diff_idx
);

  cmp_state_t       state_q, state_d;
  logic [W-1:0]     sa_q, sa_d;
  logic [W-1:0]     sb_q, sb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [IDX_W-1:0] diff_idx_q, diff_idx_d;

  logic cell_eq, cell_gt, cell_lt;

  cmp_bit_cell u_cell (
    .x  (sa_q[W-1]),
    .y  (sb_q[W-1]),
    .eq (cell_eq),
    .gt (cell_gt),
    .lt (cell_lt)
  );

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    idx_d      = idx_q;
    eq_d       = eq_q;
    gt_d       = gt_q;
    lt_d       = lt_q;
    diff_idx_d = diff_idx_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          idx_d   = IDX_W'(W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cell_gt) begin
          gt_d       = 1'b1;
          diff_idx_d = idx_q;
          state_d    = DONE;
        end else if (cell_lt) begin
          lt_d       = 1'b1;
          diff_idx_d = idx_q;
          state_d    = DONE;
        end else if (cell_eq && idx_q == '0) begin
          eq_d       = 1'b1;
          diff_idx_d = '0;
          state_d    = DONE;
        end else begin
          sa_d  = {sa_q[W-2:0], 1'b0};
          sb_d  = {sb_q[W-2:0], 1'b0};
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          eq_d       = 1'b0;
          gt_d       = 1'b0;
          lt_d       = 1'b0;
          diff_idx_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      idx_q      <= '0;
      eq_q       <= 1'b0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      diff_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      idx_q      <= idx_d;
      eq_q       <= eq_d;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
      diff_idx_q <= diff_idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign equal     = eq_q;
  assign greater   = gt_q;
  assign lower     = lt_q;
  assign diff_idx  = diff_idx_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed bench for serial_mag_cmp with a queue of expected results and
// immediate-assertion checks on each observed output.
module tb_serial_mag_cmp;

  localparam int W     = 8;
  localparam int IDX_W = $clog2(W);

  typedef struct {
    logic             eq;
    logic             gt;
    logic             lt;
    logic [IDX_W-1:0] idx;
    int unsigned      lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a, b;
  logic             out_valid;
  logic             out_ready;
  logic             equal, greater, lower;
  logic [IDX_W-1:0] diff_idx;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t        sb_q[$];

  serial_mag_cmp #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .equal     (equal),
    .greater   (greater),
    .lower     (lower),
    .diff_idx  (diff_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: scan bits MSB-first for the first difference.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.eq  = 1'b1;
    e.gt  = 1'b0;
    e.lt  = 1'b0;
    e.idx = '0;
    e.lat = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) begin
        e.eq  = 1'b0;
        e.gt  = x[i];
        e.lt  = y[i];
        e.idx = IDX_W'(i);
        e.lat = int'(W - i);
        break;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid, counting edges since the accept edge.
  task automatic wait_result(input string tag, output int unsigned lat);
    lat = 0;
    while (!out_valid && lat <= W + 2) begin
      step();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int unsigned lat);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_equal"}, 64'(equal), 64'(e.eq));
    chk({tag, "_greater"}, 64'(greater), 64'(e.gt));
    chk({tag, "_lower"}, 64'(lower), 64'(e.lt));
    chk({tag, "_diff_idx"}, 64'(diff_idx), 64'(e.idx));
  endtask

  // One operation; optionally hold out_ready low while offering new operands.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int unsigned hold);
    int unsigned lat;
    exp_t        e;
    chk({tag, "_in_ready_pre"}, 64'(in_ready), 64'(1));
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    e        = model(xa, xb);
    sb_q.push_back(e);
    step();
    in_valid = 1'b0;
    wait_result(tag, lat);
    check_result(tag, lat);
    for (int unsigned i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = ~xa;
      b        = xa;
      step();
      chk({tag, "_bp_valid"}, 64'(out_valid), 64'(1));
      chk({tag, "_bp_in_ready"}, 64'(in_ready), 64'(0));
      chk({tag, "_bp_greater"}, 64'(greater), 64'(e.gt));
      chk({tag, "_bp_lower"}, 64'(lower), 64'(e.lt));
      chk({tag, "_bp_equal"}, 64'(equal), 64'(e.eq));
      chk({tag, "_bp_diff_idx"}, 64'(diff_idx), 64'(e.idx));
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_post_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_post_flags"}, 64'({equal, greater, lower}), 64'(0));
    step();
    chk({tag, "_no_stray_accept"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int unsigned lat;
    exp_t        e;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_flags", 64'({equal, greater, lower}), 64'(0));
    chk("rst_diff_idx", 64'(diff_idx), 64'(0));
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_release_in_ready", 64'(in_ready), 64'(1));

    // Reset mid-operation: result discarded, outputs cleared asynchronously.
    a        = 8'hF0;
    b        = 8'h0F;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_flags", 64'({equal, greater, lower}), 64'(0));
    chk("midrst_diff_idx", 64'(diff_idx), 64'(0));
    step();
    rst = 1'b0;
    step();
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("midrst_no_result", 64'(out_valid), 64'(0));
    end

    run_op("msb_exit", 8'hA5, 8'h25, 0);
    run_op("lsb_diff", 8'h10, 8'h11, 0);
    run_op("equal_ops", 8'h3C, 8'h3C, 0);
    run_op("backpressure", 8'h40, 8'h30, 5);

    // Back-to-back with out_ready and in_valid held high.
    out_ready = 1'b1;
    a         = 8'h01;
    b         = 8'h02;
    in_valid  = 1'b1;
    sb_q.push_back(model(8'h01, 8'h02));
    step();
    a = 8'hFF;
    b = 8'h7F;
    e = model(8'hFF, 8'h7F);
    wait_result("b2b_first", lat);
    check_result("b2b_first", lat);
    sb_q.push_back(e);
    step();
    chk("b2b_handshake_clear", 64'(out_valid), 64'(0));
    chk("b2b_handshake_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    chk("b2b_accept_no_valid", 64'(out_valid), 64'(0));
    step();
    check_result("b2b_second", e.lat);
    step();
    out_ready = 1'b0;
    chk("b2b_final_clear", 64'(out_valid), 64'(0));
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
